pll_lock_supervisor: RTL and testbench



---
 rtl/pll_lock_supervisor.sv | 113 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock wait with timeout/retry, lock qualification and system reset release.
// Latency: lock_in to action is 3 edges; backpressure: none, free-running sequencer.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_BITS       = 8
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                lock_in,
  output logic                pll_nrst,
  output logic                sys_nrst,
  output logic                locked,
  output logic [2:0]          state,
  output logic [CNT_BITS-1:0] loss_count,
  output logic [CNT_BITS-1:0] retry_count
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > TIMEOUT_CYCLES) ? PLL_RST_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int TW      = $clog2(MAX_CYC);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    QUALIFY   = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4
  } state_e;

  // Held as a plain vector so the illegal codes 5-7 are representable.
  logic [2:0]          state_q;
  state_e              state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                sync1_q, sync2_q;
  logic                pll_nrst_q, sys_nrst_q, locked_q;
  logic [CNT_BITS-1:0] loss_q, loss_d;
  logic [CNT_BITS-1:0] retry_q, retry_d;
  logic                lock_s;

  assign lock_s = sync2_q;

  always_comb begin
    state_d = PLL_RST;
    loss_d  = loss_q;
    retry_d = retry_q;
    case (state_q)
      PLL_RST: begin
        state_d = PLL_RST;
        if (timer_q == TW'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        state_d = WAIT_LOCK;
        // Lock arriving on the timeout cycle takes priority over the retry.
        if (lock_s) begin
          state_d = QUALIFY;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = PLL_RST;
          if (retry_q != '1) retry_d = retry_q + 1'b1;
        end
      end
      QUALIFY: begin
        state_d = QUALIFY;
        if (!lock_s) state_d = WAIT_LOCK;
        else if (timer_q == TW'(STABLE_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        state_d = RUN;
        if (!lock_s) begin
          state_d = LOST;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end
      end
      LOST:    state_d = PLL_RST;
      default: state_d = PLL_RST;
    endcase
    timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= PLL_RST;
      timer_q    <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      pll_nrst_q <= 1'b0;
      sys_nrst_q <= 1'b0;
      locked_q   <= 1'b0;
      loss_q     <= '0;
      retry_q    <= '0;
    end else begin
      sync1_q    <= lock_in;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      // Decoded from the next state so the registered outputs line up with state_q.
      pll_nrst_q <= (state_d != PLL_RST);
      sys_nrst_q <= (state_d == RUN);
      locked_q   <= (state_d == RUN);
      loss_q     <= loss_d;
      retry_q    <= retry_d;
    end
  end

  assign pll_nrst    = pll_nrst_q;
  assign sys_nrst    = sys_nrst_q;
  assign locked      = locked_q;
  assign state       = state_q;
  assign loss_count  = loss_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters (4/32/8/4).
module tb_pll_lock_supervisor;

  logic       clk = 1'b0;
  logic       nrst;
  logic       lock_in;
  logic       pll_nrst, sys_nrst, locked;
  logic [2:0] state;
  logic [3:0] loss_count, retry_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int n        = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES(4),
    .TIMEOUT_CYCLES(32),
    .STABLE_CYCLES (8),
    .CNT_BITS      (4)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .lock_in    (lock_in),
    .pll_nrst   (pll_nrst),
    .sys_nrst   (sys_nrst),
    .locked     (locked),
    .state      (state),
    .loss_count (loss_count),
    .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   n;
    logic lk_next;
    int   st;
    logic pll;
    logic sys;
    logic lkd;
    int   loss;
    int   retry;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
  endtask

  task automatic check_outs(input string tag, input int st, input int pll, input int sys,
                            input int lkd, input int loss, input int retry);
    check({tag, ".state"}, int'(state), st);
    check({tag, ".pll_nrst"}, int'(pll_nrst), pll);
    check({tag, ".sys_nrst"}, int'(sys_nrst), sys);
    check({tag, ".locked"}, int'(locked), lkd);
    check({tag, ".loss"}, int'(loss_count), loss);
    check({tag, ".retry"}, int'(retry_count), retry);
  endtask

  // Advance to just after edge 'target' (edges counted from reset release).
  task automatic go_to(input int target);
    while (n < target) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  task automatic do_reset(input logic lk);
    nrst    = 1'b0;
    lock_in = lk;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    nrst = 1'b1;
    n    = 0;
  endtask

  initial begin
    nrst    = 1'b0;
    lock_in = 1'b1;

    // Clean start, lock loss at t=20, recovery.
    tbl[0]  = '{3,  1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{4,  1'b1, 1, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{5,  1'b1, 2, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{12, 1'b1, 2, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[4]  = '{13, 1'b1, 3, 1'b1, 1'b1, 1'b1, 0, 0};
    tbl[5]  = '{19, 1'b0, 3, 1'b1, 1'b1, 1'b1, 0, 0};
    tbl[6]  = '{20, 1'b0, 3, 1'b1, 1'b1, 1'b1, 0, 0};
    tbl[7]  = '{21, 1'b0, 3, 1'b1, 1'b1, 1'b1, 0, 0};
    tbl[8]  = '{22, 1'b0, 4, 1'b1, 1'b0, 1'b0, 1, 0};
    tbl[9]  = '{23, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1, 0};
    tbl[10] = '{27, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1, 0};
    tbl[11] = '{28, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1, 0};
    tbl[12] = '{35, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1, 0};
    tbl[13] = '{36, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1, 0};

    do_reset(1'b1);
    for (int i = 0; i < 14; i++) begin
      go_to(tbl[i].n);
      check_outs($sformatf("vec%0d", i), tbl[i].st, int'(tbl[i].pll), int'(tbl[i].sys),
                 int'(tbl[i].lkd), tbl[i].loss, tbl[i].retry);
      lock_in = tbl[i].lk_next;
    end

    // Reset for one edge while in RUN.
    go_to(40);
    check("pre_rst.state", int'(state), 3);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    check_outs("rst_run", 0, 0, 0, 0, 0, 0);
    nrst = 1'b1;
    n    = 0;

    // Timeout retry with lock held low.
    do_reset(1'b0);
    go_to(35);
    check("to.state35", int'(state), 1);
    check("to.retry35", int'(retry_count), 0);
    go_to(36);
    check("to.state36", int'(state), 0);
    check("to.retry36", int'(retry_count), 1);
    go_to(39);
    check("to.pll39", int'(pll_nrst), 0);
    go_to(40);
    check("to.pll40", int'(pll_nrst), 1);
    go_to(72);
    check("to.retry72", int'(retry_count), 2);
    go_to(539);
    check("to.retry539", int'(retry_count), 14);
    go_to(540);
    check("to.retry540", int'(retry_count), 15);
    go_to(612);
    check("to.sat", int'(retry_count), 15);
    check("to.sys", int'(sys_nrst), 0);

    // Qualify abort then re-qualify.
    do_reset(1'b1);
    go_to(7);
    check("qa.state7", int'(state), 2);
    lock_in = 1'b0;
    go_to(9);
    check("qa.state9", int'(state), 2);
    go_to(10);
    check("qa.state10", int'(state), 1);
    check("qa.sys10", int'(sys_nrst), 0);
    go_to(12);
    lock_in = 1'b1;
    go_to(14);
    check("qa.state14", int'(state), 1);
    go_to(15);
    check("qa.state15", int'(state), 2);
    go_to(22);
    check("qa.sys22", int'(sys_nrst), 0);
    go_to(23);
    check_outs("qa23", 3, 1, 1, 1, 0, 0);

    // Lock arriving exactly on the timeout cycle wins.
    do_reset(1'b0);
    go_to(33);
    lock_in = 1'b1;
    go_to(35);
    check("bd.state35", int'(state), 1);
    go_to(36);
    check("bd.state36", int'(state), 2);
    check("bd.retry36", int'(retry_count), 0);

    // Illegal state code recovers to PLL_RST.
    go_to(40);
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    check("ill.forced", int'(state), 6);
    @(posedge clk);
    #1;
    check("ill.state", int'(state), 0);
    check("ill.pll", int'(pll_nrst), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
